// File: rtl/teclado_pkg.sv
// rtl/teclado_pkg.sv - PS/2 Set-2 scan code constants and key code decode
package teclado_pkg;

  localparam int KC_W = 5;

  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_B     = 8'h32;
  localparam logic [7:0] SC_C     = 8'h21;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_E     = 8'h24;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;

  localparam logic [KC_W-1:0] KC_ENTER = 5'h10;
  localparam logic [KC_W-1:0] KC_BKSP  = 5'h11;
  localparam logic [KC_W-1:0] KC_ESC   = 5'h12;

  // Returns {hit, code}; prefixes and any unlisted code come back with hit = 0.
  function automatic logic [KC_W:0] sc2kc(input logic [7:0] sc);
    logic [KC_W:0] r;
    r = '0;
    case (sc)
      SC_0:     r = {1'b1, 5'h00};
      SC_1:     r = {1'b1, 5'h01};
      SC_2:     r = {1'b1, 5'h02};
      SC_3:     r = {1'b1, 5'h03};
      SC_4:     r = {1'b1, 5'h04};
      SC_5:     r = {1'b1, 5'h05};
      SC_6:     r = {1'b1, 5'h06};
      SC_7:     r = {1'b1, 5'h07};
      SC_8:     r = {1'b1, 5'h08};
      SC_9:     r = {1'b1, 5'h09};
      SC_A:     r = {1'b1, 5'h0A};
      SC_B:     r = {1'b1, 5'h0B};
      SC_C:     r = {1'b1, 5'h0C};
      SC_D:     r = {1'b1, 5'h0D};
      SC_E:     r = {1'b1, 5'h0E};
      SC_F:     r = {1'b1, 5'h0F};
      SC_ENTER: r = {1'b1, KC_ENTER};
      SC_BKSP:  r = {1'b1, KC_BKSP};
      SC_ESC:   r = {1'b1, KC_ESC};
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - first-word-fall-through synchronous FIFO with occupancy count
module fifo_sync #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = rd_en & ~empty;
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign do_push = wr_en & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/teclado_buffer.sv
// rtl/teclado_buffer.sv - key release detect, scan code decode and key code queue
module teclado_buffer
  import teclado_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = KC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     datolisto,
  input  logic [7:0]               tecla,
  output logic [CW-1:0]            key_code,
  output logic                     key_valid,
  input  logic                     key_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [7:0]               unk_cnt
);

  logic          dl_q;
  logic          ev_r;
  logic [7:0]    sc_r;
  logic [KC_W:0] dec;
  logic          hit;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_req;
  logic          push_drop;

  assign dec       = sc2kc(sc_r);
  assign hit       = dec[KC_W];
  assign key_valid = ~empty;
  assign pop       = key_valid & key_ready;
  assign push_req  = ev_r & hit;
  assign push_drop = push_req & full & ~pop;

  // Stage 1: the detector's falling ready flag marks a completed release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_q <= 1'b0;
      ev_r <= 1'b0;
      sc_r <= '0;
    end else begin
      dl_q <= datolisto;
      ev_r <= dl_q & ~datolisto;
      if (dl_q & ~datolisto) sc_r <= tecla;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // A clear coinciding with an unmapped code restarts the count at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unk_cnt <= '0;
    end else if (ev_r & ~hit) begin
      if (ovf_clr)               unk_cnt <= 8'd1;
      else if (unk_cnt != 8'hFF) unk_cnt <= unk_cnt + 8'd1;
    end else if (ovf_clr) begin
      unk_cnt <= '0;
    end
  end

  fifo_sync #(
    .WIDTH (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_req),
    .wr_data (dec[CW-1:0]),
    .rd_en   (key_ready),
    .rd_data (key_code),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

endmodule

// File: tb/tb_teclado_buffer.sv
// tb/tb_teclado_buffer.sv - scoreboard bench for teclado_buffer
module tb_teclado_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       datolisto;
  logic [7:0] tecla;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] count;
  logic       overflow;
  logic       ovf_clr;
  logic [7:0] unk_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] exp_q [$];

  logic [7:0] sc_tab [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                              8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

  teclado_buffer #(.DEPTH(8), .CW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .datolisto (datolisto),
    .tecla     (tecla),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .count     (count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .unk_cnt   (unk_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head is checked against the oldest expected code.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", int'(key_code), 32'hFFFF);
        end else begin
          chk("pop_order", int'(key_code), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic key_event(input logic [7:0] sc, input logic pushed, input logic [4:0] kc);
    if (pushed) exp_q.push_back(kc);
    tecla = sc;
    datolisto = 1'b1;
    tick();
    datolisto = 1'b0;
    repeat (3) tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    key_ready = 1'b1;
    while (key_valid && n < 40) begin
      tick();
      n++;
    end
    key_ready = 1'b0;
    chk("drain_count", int'(count), 0);
    chk("drain_queue_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; datolisto = 1'b0; tecla = 8'h00; key_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_unk", int'(unk_cnt), 0);
    chk("rst_code", int'(key_code), 0);

    // Latency: fall sampled at edge N, key_valid after N+1.
    exp_q.push_back(5'h01);
    tecla = 8'h16; datolisto = 1'b1;
    tick();
    datolisto = 1'b0;
    tick();
    chk("lat_n_valid", int'(key_valid), 0);
    tick();
    chk("lat_n1_valid", int'(key_valid), 1);
    chk("lat_code", int'(key_code), 5'h01);
    chk("lat_count", int'(count), 1);
    drain();
    chk("pop_valid", int'(key_valid), 0);

    // Letter and commands held back, then released in order.
    key_event(8'h1C, 1'b1, 5'h0A);
    key_event(8'h5A, 1'b1, 5'h10);
    key_event(8'h66, 1'b1, 5'h11);
    key_event(8'h76, 1'b1, 5'h12);
    chk("seq_count", int'(count), 4);
    chk("seq_head_stable", int'(key_code), 5'h0A);
    drain();

    // Unmapped codes are counted, not queued.
    key_event(8'h12, 1'b0, 5'h00);
    key_event(8'hE0, 1'b0, 5'h00);
    chk("unk_cnt2", int'(unk_cnt), 2);
    chk("unk_count", int'(count), 0);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("unk_clr", int'(unk_cnt), 0);

    // Overflow: nine events into eight entries, ninth lost.
    for (int i = 0; i < 9; i++) key_event(sc_tab[i], i < 8, 5'(i));
    chk("ovf_count", int'(count), 8);
    chk("ovf_flag", int'(overflow), 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", int'(overflow), 0);
    drain();

    // Full FIFO with push and pop on the same edge, wrapping the pointers.
    for (int i = 0; i < 8; i++) key_event(sc_tab[i], 1'b1, 5'(i));
    chk("full_count", int'(count), 8);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(5'((i + 8) % 16));
      tecla = sc_tab[(i + 8) % 16];
      datolisto = 1'b1;
      tick();
      datolisto = 1'b0;
      tick();
      key_ready = 1'b1;
      tick();
      key_ready = 1'b0;
      chk("pp_count", int'(count), 8);
      chk("pp_overflow", int'(overflow), 0);
      tick();
    end
    drain();

    // Reset while the stage-1 event is pending discards it.
    tecla = 8'h16; datolisto = 1'b1;
    tick();
    datolisto = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("rstmid_valid", int'(key_valid), 0);
    chk("rstmid_count", int'(count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
